addsub_serial_unit: RTL and testbench

//   Multi-cycle add/subtract/compare datapath for the RISC-V core. It consumes
//   the subtract control produced by the opcode/funct decode stage. It computes
//   a+b or a-b in CHUNK-bit slices, one slice per cycle, to save FPGA area.
//   It produces the result and the condition flags used by branch resolution
//   and SLT/SLTU. A start/busy/done handshake connects it to the execute-stage

---
 rtl/addsub_serial_unit.sv | 135 +++++++++++++
 tb/tb_addsub_serial_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial_unit.sv
// Slice-serial add/subtract unit: CHUNK bits per cycle with a start/busy/done handshake.
// It produces the result plus the Z/N/C/V and signed/unsigned less-than flags for branches and SLT.
module addsub_serial_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_lt,
  output logic             flag_ltu
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("addsub_serial_unit: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic             sub_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             z_q, n_q, c_q, v_q, lt_q, ltu_q;

  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] res_d;
  logic             last_slice;
  logic             v_d;
  logic             n_d;
  int               base;

  // One slice of the ripple sum, merged into the partial result so the final edge sees the full word.
  always_comb begin
    base       = int'(cnt_q) * CHUNK;
    slice_sum  = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
               + {{CHUNK{1'b0}}, carry_q};
    res_d      = acc_q;
    res_d[base +: CHUNK] = slice_sum[CHUNK-1:0];
    last_slice = (cnt_q == CW'(N - 1));
    n_d        = res_d[WIDTH-1];
    v_d        = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (n_d != a_q[WIDTH-1]);
  end

  // b_q holds the inverted operand for subtraction, so the carry-in of 1 completes the two's complement.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            sub_q   <= sub;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          acc_q   <= res_d;
          carry_q <= slice_sum[CHUNK];
          cnt_q   <= cnt_q + CW'(1);
          if (last_slice) begin
            result_q <= res_d;
            z_q      <= (res_d == '0);
            n_q      <= n_d;
            c_q      <= slice_sum[CHUNK];
            v_q      <= v_d;
            lt_q     <= sub_q & (n_d ^ v_d);
            ltu_q    <= sub_q & ~slice_sum[CHUNK];
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign flag_z   = z_q;
  assign flag_n   = n_q;
  assign flag_c   = c_q;
  assign flag_v   = v_q;
  assign flag_lt  = lt_q;
  assign flag_ltu = ltu_q;

endmodule

// File: tb/tb_addsub_serial_unit.sv
// Self-checking bench for addsub_serial_unit: directed table, random ops against an arithmetic model,
// back-to-back handshake and mid-operation reset sequences.
module tb_addsub_serial_unit;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        flag_z, flag_n, flag_c, flag_v, flag_lt, flag_ltu;
  logic [5:0]  dutFlags;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [5:0]  flags;
  } vec_t;

  vec_t vectors[8];

  addsub_serial_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub),
    .busy(busy), .done(done), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .flag_lt(flag_lt), .flag_ltu(flag_ltu)
  );

  assign dutFlags = {flag_z, flag_n, flag_c, flag_v, flag_lt, flag_ltu};

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Expected values from plain integer arithmetic: {z, n, c, v, lt, ltu}.
  task automatic refModel(input logic [31:0] x, input logic [31:0] y, input logic s,
                          output logic [31:0] r, output logic [5:0] f);
    longint sx, sy, sres, ux, uy;
    logic c, v, lt, ltu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    if (s) begin
      r    = x - y;
      sres = sx - sy;
      c    = (ux >= uy);
      lt   = (sx < sy);
      ltu  = (ux < uy);
    end else begin
      r    = x + y;
      sres = sx + sy;
      c    = ((ux + uy) > 64'sd4294967295);
      lt   = 1'b0;
      ltu  = 1'b0;
    end
    v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    f = {(r == 32'h0), r[31], c, v, lt, ltu};
  endtask

  // Issue one op, scramble inputs after capture, then check latency, busy window, hold and final outputs.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic s,
                               input logic [31:0] expRes, input logic [5:0] expFlags, input string tag);
    logic [31:0] prevRes;
    int          edges;
    bit          seen;
    bit          busyOk;
    prevRes = result;
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
    edges = 1; seen = 0; busyOk = 1;
    while (!seen && edges <= 20) begin
      if (done) seen = 1;
      else begin
        if (!busy || result !== prevRes) busyOk = 0;
        @(posedge clk);
        @(negedge clk);
        edges++;
      end
    end
    checkOutput({tag, " latency"}, 32'(edges), 32'(N + 1));
    checkOutput({tag, " busy/hold in flight"}, {31'b0, busyOk}, 32'd1);
    checkOutput({tag, " busy at done"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, " result"}, result, expRes);
    checkOutput({tag, " flags"}, {26'b0, dutFlags}, {26'b0, expFlags});
    @(negedge clk);
    checkOutput({tag, " done one cycle"}, {31'b0, done}, 32'd0);
    checkOutput({tag, " result held"}, result, expRes);
  endtask

  initial begin
    logic [31:0] er, x, y;
    logic [5:0]  ef;
    logic        s;
    int          doneEdges[$];
    int          edges;
    int          pulses;
    logic [31:0] hsRes;
    logic [5:0]  hsFlags;

    vectors[0] = '{1'b1, 32'd5,          32'd3,          32'd2,          6'b001000};
    vectors[1] = '{1'b1, 32'd3,          32'd5,          32'hFFFFFFFE,   6'b010011};
    vectors[2] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'h0,          6'b101000};
    vectors[3] = '{1'b1, 32'h80000000,   32'd1,          32'h7FFFFFFF,   6'b001110};
    vectors[4] = '{1'b0, 32'h7FFFFFFF,   32'd1,          32'h80000000,   6'b010100};
    vectors[5] = '{1'b1, 32'h12345678,   32'h12345678,   32'h0,          6'b101000};
    vectors[6] = '{1'b0, 32'h000000FF,   32'h00000001,   32'h00000100,   6'b000000};
    vectors[7] = '{1'b1, 32'h0,          32'h80000000,   32'h80000000,   6'b010101};

    // Reset, with start asserted to show reset wins.
    rst = 1'b1; start = 1'b1; a = 32'hDEADBEEF; b = 32'h1; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset result", result, 32'h0);
    checkOutput("reset flags", {26'b0, dutFlags}, 32'h0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      applyStimulus(vectors[i].a, vectors[i].b, vectors[i].sub, vectors[i].res, vectors[i].flags,
                    $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      case ($urandom_range(0, 4))
        0: y = x;
        1: y = 32'h80000000;
        2: y = 32'hFFFFFFFF;
        default: y = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      refModel(x, y, s, er, ef);
      applyStimulus(x, y, s, er, ef, $sformatf("rand%0d", i));
    end

    // Start held high: ignored while busy, accepted in the DONE cycle with that cycle's operands.
    refModel(32'd10, 32'd4, 1'b0, hsRes, hsFlags);
    @(negedge clk);
    a = 32'd5; b = 32'd3; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    edges = 1;
    while (edges <= 12) begin
      if (done) begin
        doneEdges.push_back(edges);
        if (doneEdges.size() == 2) begin
          checkOutput("handshake second result", result, hsRes);
          checkOutput("handshake second flags", {26'b0, dutFlags}, {26'b0, hsFlags});
        end
      end
      if (done && doneEdges.size() == 1) begin
        a = 32'd10; b = 32'd4; sub = 1'b0;
      end else begin
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    checkOutput("handshake done count", 32'(doneEdges.size()), 32'd2);
    if (doneEdges.size() == 2) begin
      checkOutput("handshake first done", 32'(doneEdges[0]), 32'(N + 1));
      checkOutput("handshake done spacing", 32'(doneEdges[1] - doneEdges[0]), 32'(N + 1));
    end
    edges = 0;
    while ((busy || done) && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("handshake drain", {31'b0, busy | done}, 32'd0);

    // Reset in the 3rd BUSY cycle discards the op with no done pulse.
    applyStimulus(vectors[0].a, vectors[0].b, vectors[0].sub, vectors[0].res, vectors[0].flags, "pre-reset");
    @(negedge clk);
    a = 32'd5; b = 32'd3; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("busy before mid reset", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid reset busy", {31'b0, busy}, 32'd0);
    checkOutput("mid reset result", result, 32'h0);
    checkOutput("mid reset flags", {26'b0, dutFlags}, 32'h0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("no done after reset", 32'(pulses), 32'd0);
    checkOutput("result after reset", result, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
